// File: rtl/bram_flw_fifo_pkg.sv
// Shared types and helpers for the single-clock BRAM FIFO.
// Holds the output-stage state type, the statistics width and a clog2 helper.
package bram_flw_fifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } stage_t;

  localparam int STAT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdp_bram_ram.sv
// Inferred simple-dual-port RAM: one write port, one registered read port.
// The read register holds its value unless a read is issued and clears on rst.
module sdp_bram_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port with enable
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bram_flw_sync_fifo.sv
// Single-clock BRAM FIFO with std/fwft read modes, programmable thresholds and error pulses.
// Optional statistics counters are built when BRAM_FLW_SYNC_FIFO_STATS_EN is defined.
module bram_flw_sync_fifo
  import bram_flw_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int FWFT   = 1,
  parameter int CNT_W  = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              half_full,
  output logic              prog_full,
  input  logic [CNT_W-1:0]  prog_full_thresh,
  output logic              overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              prog_empty,
  input  logic [CNT_W-1:0]  prog_empty_thresh,
  output logic              underflow,
  output logic [CNT_W-1:0]  data_count,
  output logic [STAT_W-1:0] ovf_cnt,
  output logic [STAT_W-1:0] unf_cnt,
  output logic [CNT_W-1:0]  peak_count
);

  localparam int ADDR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  HALF_C  = CNT_W'(DEPTH / 2);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ram_re;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] ram_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Occupancy after this edge's accepted requests
  always_comb begin
    cnt_nxt = data_count;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = data_count + CNT_ONE;
      2'b01:   cnt_nxt = data_count - CNT_ONE;
      default: cnt_nxt = data_count;
    endcase
  end

  // Count, count-derived flags, error pulses and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_count <= '0;
      full       <= 1'b0;
      half_full  <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      data_count <= cnt_nxt;
      full       <= (cnt_nxt == DEPTH_C);
      half_full  <= (data_count > HALF_C);
      prog_full  <= (cnt_nxt >= prog_full_thresh);
      prog_empty <= (cnt_nxt <= prog_empty_thresh);
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_re) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  sdp_bram_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  if (FWFT != 0) begin : g_fwft
    // Stage a is the RAM read register, stage b the output register seen as dout.
    stage_t           a_st, a_nxt, b_st, b_nxt;
    logic             b_load;
    logic             a_fetch;
    logic [CNT_W-1:0] unread;

    // Prefetch control for both stages
    always_comb begin
      unread  = data_count - {{(CNT_W-1){1'b0}}, a_st == VALID}
                           - {{(CNT_W-1){1'b0}}, b_st == VALID};
      b_load  = (b_st == IDLE) || rd_acc;
      a_fetch = ((a_st == IDLE) || b_load) && (unread != '0);
      b_nxt   = b_st;
      a_nxt   = a_st;
      if (b_load) begin
        b_nxt = a_st;
      end else begin
        b_nxt = b_st;
      end
      if (a_fetch) begin
        a_nxt = VALID;
      end else if (b_load) begin
        a_nxt = IDLE;
      end else begin
        a_nxt = a_st;
      end
    end

    // Stage state and output register
    always_ff @(posedge clk) begin
      if (rst) begin
        a_st <= IDLE;
        b_st <= IDLE;
        dout <= '0;
      end else begin
        a_st <= a_nxt;
        b_st <= b_nxt;
        if (b_load && (a_st == VALID)) begin
          dout <= ram_q;
        end
      end
    end

    assign ram_re = a_fetch;
    assign empty  = (b_st == IDLE);
  end else begin : g_std
    logic empty_q;

    // Standard mode: empty follows the count
    always_ff @(posedge clk) begin
      if (rst) begin
        empty_q <= 1'b1;
      end else begin
        empty_q <= (cnt_nxt == '0);
      end
    end

    assign ram_re = rd_acc;
    assign dout   = ram_q;
    assign empty  = empty_q;
  end

`ifdef BRAM_FLW_SYNC_FIFO_STATS_EN
  // Saturating reject counters and occupancy high-water mark
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt    <= '0;
      unf_cnt    <= '0;
      peak_count <= '0;
    end else begin
      if (wr_en && full && (ovf_cnt != {STAT_W{1'b1}})) begin
        ovf_cnt <= ovf_cnt + STAT_W'(1);
      end
      if (rd_en && empty && (unf_cnt != {STAT_W{1'b1}})) begin
        unf_cnt <= unf_cnt + STAT_W'(1);
      end
      if (data_count > peak_count) begin
        peak_count <= data_count;
      end
    end
  end
`else
  assign ovf_cnt    = '0;
  assign unf_cnt    = '0;
  assign peak_count = '0;
`endif

endmodule
